// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter / return-stack block:
// default geometry constants and the command-priority encoding.
package pc_pkg;

  localparam int unsigned PC_WIDTH_DEFAULT = 16;
  localparam int unsigned PC_DEPTH_DEFAULT = 4;
  localparam int unsigned PC_STEP_DEFAULT  = 1;

  // One command wins per cycle; the encoding order mirrors the priority
  // (higher value = higher priority) so a glance at a waveform tells the winner.
  typedef enum logic [2:0] {
    CMD_NONE      = 3'd0,
    CMD_INCREMENT = 3'd1,
    CMD_LOAD      = 3'd2,
    CMD_BRANCH    = 3'd3,
    CMD_CALL      = 3'd4,
    CMD_RETURN    = 3'd5
  } cmd_e;

  // Collapse the raw command strobes into the single command that takes effect.
  function automatic cmd_e decode_cmd(
    input logic ret,
    input logic call,
    input logic branch,
    input logic load,
    input logic increment
  );
    if (ret) begin
      return CMD_RETURN;
    end else if (call) begin
      return CMD_CALL;
    end else if (branch) begin
      return CMD_BRANCH;
    end else if (load) begin
      return CMD_LOAD;
    end else if (increment) begin
      return CMD_INCREMENT;
    end
    return CMD_NONE;
  endfunction

endpackage

// File: rtl/pc_lifo.sv
// Return-address LIFO. Only the entry count is reset; entry contents are
// left unreset because they are never read while the stack is empty.
// Push on a full stack and pop on an empty stack are ignored here; the
// parent is responsible for flagging them.
module pc_lifo #(
  parameter int unsigned WIDTH = pc_pkg::PC_WIDTH_DEFAULT,
  parameter int unsigned DEPTH = pc_pkg::PC_DEPTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]    count;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty && !push;
  // Count indexes the next free slot; the top entry sits one below it.
  assign wr_idx  = count[AW-1:0];
  assign rd_idx  = count[AW-1:0] - 1'b1;
  assign top     = mem[rd_idx];

  // Entry count: the only reset state in the LIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (push_ok) begin
      count <= count + 1'b1;
    end else if (pop_ok) begin
      count <= count - 1'b1;
    end
  end

  // Entry storage, written on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_idx] <= data;
    end
  end

endmodule

// File: rtl/pc_stack_register.sv
// Program counter with load / increment / branch and a call/return stack.
// Priority per cycle: RETURN > CALL > BRANCH > LOAD > INCREMENT.
// DATAOUT is a register: every command shows up one edge later.
// Optional feature macro: PC_STACK_ERROR_EN enables the sticky
// overflow/underflow ERROR flag; when undefined ERROR is tied low.
module pc_stack_register
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = PC_WIDTH_DEFAULT,
  parameter int unsigned DEPTH = PC_DEPTH_DEFAULT,
  parameter int unsigned STEP  = PC_STEP_DEFAULT
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             LOAD,
  input  logic             INCREMENT,
  input  logic             BRANCH,
  input  logic             CALL,
  input  logic             RETURN,
  input  logic [WIDTH-1:0] DATAIN,
  input  logic [WIDTH-1:0] OFFSET,
  output logic [WIDTH-1:0] DATAOUT,
  output logic             STACK_FULL,
  output logic             STACK_EMPTY,
  output logic             ERROR
);

  // STEP is truncated to WIDTH bits so all adds wrap modulo 2^WIDTH.
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  cmd_e             cmd;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] ret_addr;
  logic [WIDTH-1:0] top;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;

  assign cmd      = decode_cmd(RETURN, CALL, BRANCH, LOAD, INCREMENT);
  assign ret_addr = pc_q + STEP_W;

  pc_lifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_lifo (
    .clk   (CLOCK),
    .rst   (RESET),
    .push  (push),
    .pop   (pop),
    .data  (ret_addr),
    .top   (top),
    .full  (full),
    .empty (empty)
  );

  // Next program counter and stack strobes for the winning command.
  // A refused CALL (full) or RETURN (empty) leaves everything unchanged.
  always_comb begin
    pc_d = pc_q;
    push = 1'b0;
    pop  = 1'b0;
    unique case (cmd)
      CMD_RETURN: begin
        if (!empty) begin
          pc_d = top;
          pop  = 1'b1;
        end
      end
      CMD_CALL: begin
        if (!full) begin
          pc_d = DATAIN;
          push = 1'b1;
        end
      end
      CMD_BRANCH:    pc_d = pc_q + OFFSET;
      CMD_LOAD:      pc_d = DATAIN;
      CMD_INCREMENT: pc_d = pc_q + STEP_W;
      default:       pc_d = pc_q;
    endcase
  end

  // Program counter register.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign DATAOUT     = pc_q;
  assign STACK_FULL  = full;
  assign STACK_EMPTY = empty;

`ifdef PC_STACK_ERROR_EN
  logic overflow;
  logic underflow;
  logic error_q;

  assign overflow  = (cmd == CMD_CALL) && full;
  assign underflow = (cmd == CMD_RETURN) && empty;

  // Sticky error: set by the first refused CALL/RETURN, cleared only by reset.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      error_q <= 1'b0;
    end else if (overflow || underflow) begin
      error_q <= 1'b1;
    end
  end

  assign ERROR = error_q;
`else
  assign ERROR = 1'b0;
`endif

endmodule

// File: tb/tb_pc_stack_register.sv
// Directed bench for pc_stack_register (WIDTH=16, DEPTH=4, STEP=1).
module tb_pc_stack_register;

  localparam int W = 16;

`ifdef PC_STACK_ERROR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic         CLOCK;
  logic         RESET;
  logic         LOAD;
  logic         INCREMENT;
  logic         BRANCH;
  logic         CALL;
  logic         RETURN;
  logic [W-1:0] DATAIN;
  logic [W-1:0] OFFSET;
  logic [W-1:0] DATAOUT;
  logic         STACK_FULL;
  logic         STACK_EMPTY;
  logic         ERROR;

  int errors = 0;
  int checks = 0;

  pc_stack_register #(
    .WIDTH (16),
    .DEPTH (4),
    .STEP  (1)
  ) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .LOAD        (LOAD),
    .INCREMENT   (INCREMENT),
    .BRANCH      (BRANCH),
    .CALL        (CALL),
    .RETURN      (RETURN),
    .DATAIN      (DATAIN),
    .OFFSET      (OFFSET),
    .DATAOUT     (DATAOUT),
    .STACK_FULL  (STACK_FULL),
    .STACK_EMPTY (STACK_EMPTY),
    .ERROR       (ERROR)
  );

  // Clock and reset defaults
  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  // Drive one command set at the falling edge, let one rising edge pass,
  // then release the strobes; outputs are sampled 1 time unit after the edge.
  task automatic do_cmd(input logic ret, input logic call, input logic br,
                        input logic ld, input logic inc,
                        input logic [W-1:0] din, input logic [W-1:0] off);
    @(negedge CLOCK);
    RETURN = ret; CALL = call; BRANCH = br; LOAD = ld; INCREMENT = inc;
    DATAIN = din; OFFSET = off;
    @(posedge CLOCK);
    #1;
    RETURN = 0; CALL = 0; BRANCH = 0; LOAD = 0; INCREMENT = 0;
  endtask

  task automatic apply_reset();
    @(negedge CLOCK);
    RESET = 1'b1;
    @(negedge CLOCK);
    RESET = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    RETURN = 0; CALL = 0; BRANCH = 0; LOAD = 0; INCREMENT = 0;
    DATAIN = '0; OFFSET = '0;
    repeat (2) @(posedge CLOCK);
    #1;
    checks++; if (DATAOUT !== 16'h0000) begin errors++; $display("FAIL reset_dataout got=%h exp=%h", DATAOUT, 16'h0000); end
    checks++; if (STACK_EMPTY !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", STACK_EMPTY); end
    checks++; if (STACK_FULL !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", STACK_FULL); end
    checks++; if (ERROR !== 1'b0) begin errors++; $display("FAIL reset_error got=%b exp=0", ERROR); end
    @(negedge CLOCK);
    RESET = 1'b0;
  endtask

  task automatic test_load_increment();
    do_cmd(0, 0, 0, 1, 0, 16'h64C2, 16'h0000);
    checks++; if (DATAOUT !== 16'h64C2) begin errors++; $display("FAIL load got=%h exp=%h", DATAOUT, 16'h64C2); end
    do_cmd(0, 0, 0, 0, 1, 16'h0000, 16'h0000);
    checks++; if (DATAOUT !== 16'h64C3) begin errors++; $display("FAIL increment got=%h exp=%h", DATAOUT, 16'h64C3); end
    do_cmd(0, 0, 0, 0, 0, 16'hAAAA, 16'h1111);
    checks++; if (DATAOUT !== 16'h64C3) begin errors++; $display("FAIL hold got=%h exp=%h", DATAOUT, 16'h64C3); end
  endtask

  task automatic test_wrap();
    do_cmd(0, 0, 0, 1, 0, 16'hFFFF, 16'h0000);
    do_cmd(0, 0, 0, 0, 1, 16'h0000, 16'h0000);
    checks++; if (DATAOUT !== 16'h0000) begin errors++; $display("FAIL inc_wrap got=%h exp=%h", DATAOUT, 16'h0000); end
    do_cmd(0, 0, 0, 1, 0, 16'h0002, 16'h0000);
    do_cmd(0, 0, 1, 0, 0, 16'h0000, 16'hFFFC);
    checks++; if (DATAOUT !== 16'hFFFE) begin errors++; $display("FAIL branch_neg_wrap got=%h exp=%h", DATAOUT, 16'hFFFE); end
    do_cmd(0, 0, 1, 0, 0, 16'h0000, 16'h0010);
    checks++; if (DATAOUT !== 16'h000E) begin errors++; $display("FAIL branch_pos_wrap got=%h exp=%h", DATAOUT, 16'h000E); end
  endtask

  task automatic test_priority();
    do_cmd(0, 0, 0, 1, 1, 16'h0010, 16'h0000);
    checks++; if (DATAOUT !== 16'h0010) begin errors++; $display("FAIL load_over_inc got=%h exp=%h", DATAOUT, 16'h0010); end
    do_cmd(0, 0, 0, 1, 0, 16'h0020, 16'h0000);
    do_cmd(0, 0, 1, 1, 0, 16'h0020, 16'h0005);
    checks++; if (DATAOUT !== 16'h0025) begin errors++; $display("FAIL branch_over_load got=%h exp=%h", DATAOUT, 16'h0025); end
  endtask

  task automatic test_call_overflow();
    logic [W-1:0] tgt [4];
    tgt[0] = 16'h0200; tgt[1] = 16'h0300; tgt[2] = 16'h0400; tgt[3] = 16'h0500;
    do_cmd(0, 0, 0, 1, 0, 16'h0100, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      do_cmd(0, 1, 0, 0, 0, tgt[i], 16'h0000);
      checks++; if (DATAOUT !== tgt[i]) begin errors++; $display("FAIL call_%0d got=%h exp=%h", i, DATAOUT, tgt[i]); end
    end
    checks++; if (STACK_FULL !== 1'b1) begin errors++; $display("FAIL call_full got=%b exp=1", STACK_FULL); end
    checks++; if (ERROR !== 1'b0) begin errors++; $display("FAIL call_no_error got=%b exp=0", ERROR); end
    do_cmd(0, 1, 0, 0, 0, 16'h0600, 16'h0000);
    checks++; if (DATAOUT !== 16'h0500) begin errors++; $display("FAIL overflow_hold got=%h exp=%h", DATAOUT, 16'h0500); end
    checks++; if (ERROR !== ERR_EXP) begin errors++; $display("FAIL overflow_error got=%b exp=%b", ERROR, ERR_EXP); end
    checks++; if (STACK_FULL !== 1'b1) begin errors++; $display("FAIL overflow_full got=%b exp=1", STACK_FULL); end
  endtask

  task automatic test_return_underflow();
    logic [W-1:0] ra [4];
    ra[0] = 16'h0401; ra[1] = 16'h0301; ra[2] = 16'h0201; ra[3] = 16'h0101;
    for (int i = 0; i < 4; i++) begin
      do_cmd(1, 0, 0, 0, 0, 16'h0000, 16'h0000);
      checks++; if (DATAOUT !== ra[i]) begin errors++; $display("FAIL return_%0d got=%h exp=%h", i, DATAOUT, ra[i]); end
    end
    checks++; if (STACK_EMPTY !== 1'b1) begin errors++; $display("FAIL return_empty got=%b exp=1", STACK_EMPTY); end
    do_cmd(1, 0, 0, 0, 0, 16'h0000, 16'h0000);
    checks++; if (DATAOUT !== 16'h0101) begin errors++; $display("FAIL underflow_hold got=%h exp=%h", DATAOUT, 16'h0101); end
    checks++; if (ERROR !== ERR_EXP) begin errors++; $display("FAIL underflow_error got=%b exp=%b", ERROR, ERR_EXP); end
  endtask

  task automatic test_underflow_only();
    // Fresh reset so the underflow alone must raise the sticky flag.
    apply_reset();
    checks++; if (ERROR !== 1'b0) begin errors++; $display("FAIL error_cleared got=%b exp=0", ERROR); end
    do_cmd(0, 0, 0, 1, 0, 16'h1234, 16'h0000);
    do_cmd(1, 0, 0, 0, 0, 16'h0000, 16'h0000);
    checks++; if (DATAOUT !== 16'h1234) begin errors++; $display("FAIL empty_return_hold got=%h exp=%h", DATAOUT, 16'h1234); end
    checks++; if (ERROR !== ERR_EXP) begin errors++; $display("FAIL empty_return_error got=%b exp=%b", ERROR, ERR_EXP); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    do_cmd(0, 0, 0, 1, 0, 16'h0041, 16'h0000);
    do_cmd(0, 1, 0, 0, 0, 16'h0080, 16'h0000);
    checks++; if (STACK_EMPTY !== 1'b0) begin errors++; $display("FAIL one_entry_empty got=%b exp=0", STACK_EMPTY); end
    do_cmd(1, 1, 0, 0, 0, 16'h0999, 16'h0000);
    checks++; if (DATAOUT !== 16'h0042) begin errors++; $display("FAIL call_return_together got=%h exp=%h", DATAOUT, 16'h0042); end
    checks++; if (STACK_EMPTY !== 1'b1) begin errors++; $display("FAIL together_empty got=%b exp=1", STACK_EMPTY); end
    do_cmd(0, 1, 0, 0, 0, 16'h0300, 16'h0000);
    do_cmd(1, 0, 0, 0, 0, 16'h0000, 16'h0000);
    checks++; if (DATAOUT !== 16'h0043) begin errors++; $display("FAIL return_after_call got=%h exp=%h", DATAOUT, 16'h0043); end
    checks++; if (ERROR !== 1'b0) begin errors++; $display("FAIL b2b_no_error got=%b exp=0", ERROR); end
  endtask

  task automatic test_reset_mid_call();
    do_cmd(0, 1, 0, 0, 0, 16'h0700, 16'h0000);
    do_cmd(0, 1, 0, 0, 0, 16'h0800, 16'h0000);
    // Reset lands mid-cycle while a CALL is being presented.
    @(negedge CLOCK);
    CALL = 1'b1; DATAIN = 16'h0900;
    #2;
    RESET = 1'b1;
    #1;
    checks++; if (DATAOUT !== 16'h0000) begin errors++; $display("FAIL async_reset_dataout got=%h exp=%h", DATAOUT, 16'h0000); end
    checks++; if (STACK_EMPTY !== 1'b1) begin errors++; $display("FAIL async_reset_empty got=%b exp=1", STACK_EMPTY); end
    @(posedge CLOCK);
    #1;
    CALL = 1'b0;
    @(negedge CLOCK);
    RESET = 1'b0;
    #1;
    checks++; if (DATAOUT !== 16'h0000) begin errors++; $display("FAIL mid_call_dataout got=%h exp=%h", DATAOUT, 16'h0000); end
    checks++; if (STACK_EMPTY !== 1'b1) begin errors++; $display("FAIL mid_call_empty got=%b exp=1", STACK_EMPTY); end
    checks++; if (STACK_FULL !== 1'b0) begin errors++; $display("FAIL mid_call_full got=%b exp=0", STACK_FULL); end
    checks++; if (ERROR !== 1'b0) begin errors++; $display("FAIL mid_call_error got=%b exp=0", ERROR); end
    // The discarded CALL must leave nothing to return to.
    do_cmd(1, 0, 0, 0, 0, 16'h0000, 16'h0000);
    checks++; if (DATAOUT !== 16'h0000) begin errors++; $display("FAIL post_reset_return got=%h exp=%h", DATAOUT, 16'h0000); end
  endtask

  initial begin
    test_reset();
    test_load_increment();
    test_wrap();
    test_priority();
    test_call_overflow();
    test_return_underflow();
    test_underflow_only();
    test_back_to_back();
    test_reset_mid_call();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pc_stack_register.md
PC_STACK_REGISTER -- requirements
Module: pc_stack_register

Interface
REQ-001 SHALL have parameter WIDTH, default 16: width of the program-counter and data paths, minimum 4.
REQ-002 SHALL have parameter DEPTH, default 4: number of return-address stack entries, power of two, minimum 2.
REQ-003 SHALL have parameter STEP, default 1: increment amount, unsigned, less than 2^WIDTH.
REQ-004 SHALL have port CLOCK  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port RESET  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port LOAD  input  1  loads DATAIN into DATAOUT.
REQ-007 SHALL have port INCREMENT  input  1  adds STEP to DATAOUT.
REQ-008 SHALL have port BRANCH  input  1  adds signed OFFSET to DATAOUT.
REQ-009 SHALL have port CALL  input  1  pushes return address, then jumps to DATAIN.
REQ-010 SHALL have port RETURN  input  1  pops top of stack into DATAOUT.
REQ-011 SHALL have port DATAIN  input  WIDTH  load or call target.
REQ-012 SHALL have port OFFSET  input  WIDTH  two's-complement branch displacement.
REQ-013 SHALL have port DATAOUT  output  WIDTH  current program-counter value, registered.
REQ-014 SHALL have port STACK_FULL  output  1  high when DEPTH entries are held.
REQ-015 SHALL have port STACK_EMPTY  output  1  high when no entries are held.
REQ-016 SHALL have port ERROR  output  1  sticky overflow/underflow flag.

Function
REQ-017 SHALL obey the per-cycle priority RETURN > CALL > BRANCH > LOAD > INCREMENT; only the highest asserted command takes effect.
REQ-018 SHALL hold DATAOUT when no command is asserted.
REQ-019 SHALL update DATAOUT one cycle after the command edge (latency 1), with no combinational path from inputs to DATAOUT.
REQ-020 SHALL perform all arithmetic modulo 2^WIDTH; 2^WIDTH-1 plus STEP=1 wraps to 0, and negative OFFSET below 0 wraps.
REQ-021 SHALL, on CALL when not full, push (DATAOUT+STEP) mod 2^WIDTH and set DATAOUT to DATAIN in the same edge.
REQ-022 SHALL, on RETURN when not empty, load the top entry into DATAOUT and decrement the entry count.
REQ-023 SHALL, on CALL when full, leave DATAOUT and the stack unchanged and record overflow.
REQ-024 SHALL, on RETURN when empty, leave DATAOUT unchanged and record underflow.
REQ-025 SHALL ignore CALL in any cycle where RETURN is also asserted.
REQ-026 SHALL derive STACK_FULL and STACK_EMPTY from the registered entry count, so they reflect the stack state after each edge.
REQ-027 SHALL allow RETURN in the cycle after CALL and return the just-pushed address.

Reset
REQ-028 SHALL asynchronously force DATAOUT=0, entry count=0, STACK_EMPTY=1, STACK_FULL=0 and ERROR=0 while RESET is high.
REQ-029 SHALL treat reset asserted mid-CALL or mid-RETURN as discarding that command entirely.
REQ-030 SHALL leave stack entry contents undefined after reset; they are never read while empty.

Configuration
REQ-031 SHALL, with PC_STACK_ERROR_EN defined, drive ERROR high from the edge after the first overflow or underflow until RESET.
REQ-032 SHALL, without PC_STACK_ERROR_EN, tie ERROR to 0; REQ-023 and REQ-024 behaviour is otherwise unchanged.

Structure
REQ-033 SHALL place the command-priority enumeration and the default WIDTH, DEPTH and STEP constants in shared package pc_pkg.
REQ-034 SHALL implement the return-address storage as sub-module pc_lifo, parametrised by WIDTH and DEPTH, exposing push, pop, top, full and empty.

Verification (WIDTH=16, DEPTH=4, STEP=1, PC_STACK_ERROR_EN defined)
REQ-035 SHALL check reset then LOAD DATAIN=0x64C2 -> DATAOUT=0x64C2; next-cycle INCREMENT -> 0x64C3.
REQ-036 SHALL check DATAOUT=0xFFFF with INCREMENT -> 0x0000, and DATAOUT=0x0002 with BRANCH OFFSET=0xFFFC -> 0xFFFE.
REQ-037 SHALL check LOAD 0x0010 and INCREMENT together -> 0x0010, and LOAD 0x0020, BRANCH OFFSET=0x0005 together -> 0x0025.
REQ-038 SHALL check four CALLs from 0x0100 to targets 0x0200, 0x0300, 0x0400, 0x0500 -> STACK_FULL=1; a fifth CALL -> DATAOUT stays 0x0500 and ERROR=1.
REQ-039 SHALL check four RETURNs after REQ-038 -> DATAOUT 0x0401, 0x0301, 0x0201, 0x0101 and STACK_EMPTY=1; a fifth RETURN -> DATAOUT holds 0x0101.
REQ-040 SHALL check CALL and RETURN together with one entry 0x0042 -> DATAOUT=0x0042, STACK_EMPTY=1; then RESET mid-cycle -> all outputs at reset values.
